// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master.
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into one APB transfer and returns a one-cycle completion.
// Optional ACCESS wait-state timeout is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDR_W  = apb_pkg::ADDR_W,
  parameter int DATA_W  = apb_pkg::DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  import apb_pkg::*;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  apb_state_e        state_r;
  apb_state_e        next_state_s;
  logic              accept_s;
  logic              done_s;
  logic              timeout_s;
  logic              psel_s;
  logic              penable_s;
  logic              rsp_err_s;
  logic [DATA_W-1:0] rsp_rdata_s;

  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r;

  // Gated by presetn so the block never advertises readiness while held in reset.
  assign cmd_ready = (state_r == IDLE) & presetn;
  assign accept_s  = cmd_valid & cmd_ready;
  assign done_s    = (state_r == ACCESS) & (pready | timeout_s);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // Count ACCESS cycles that end without pready; cleared on every new command.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_r <= '0;
    end else if (accept_s) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ACCESS) && !pready) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == ACCESS) & ~pready & (wait_cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = SETUP;
        else          next_state_s = IDLE;
      end
      SETUP:   next_state_s = ACCESS;
      ACCESS: begin
        if (done_s) next_state_s = IDLE;
        else        next_state_s = ACCESS;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the next state so psel/penable come straight from flops.
  always_comb begin
    psel_s      = 1'b0;
    penable_s   = 1'b0;
    case (next_state_s)
      IDLE: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
      end
      SETUP: begin
        psel_s    = 1'b1;
        penable_s = 1'b0;
      end
      ACCESS: begin
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end
      default: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
      end
    endcase
    // A timeout has no valid slave response, so it reports an error with zero data.
    if (pready) begin
      rsp_err_s   = pslverr;
      rsp_rdata_s = pwrite_r ? '0 : prdata;
    end else begin
      rsp_err_s   = 1'b1;
      rsp_rdata_s = '0;
    end
  end

  // APB control flops and command capture; address/data hold their last values in IDLE.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= '0;
      pwdata_r  <= '0;
    end else begin
      psel_r    <= psel_s;
      penable_r <= penable_s;
      if (accept_s) begin
        pwrite_r <= cmd_write;
        paddr_r  <= cmd_addr;
        pwdata_r <= cmd_wdata;
      end else begin
        pwrite_r <= pwrite_r;
        paddr_r  <= paddr_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  // Completion flops; read data holds until the next completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= done_s;
      rsp_err_r   <= done_s ? rsp_err_s : 1'b0;
      if (done_s) begin
        rsp_rdata_r <= rsp_rdata_s;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = pwrite_r;
  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed, table-driven bench for apb_master with a small memory-backed APB slave model.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [0:255];

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Slave model: stores on a completed write, returns memory contents combinationally.
  assign prdata = mem[paddr];
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command (caller is just after a negedge) and follow it to completion or bound.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int waits, input logic err, input int bound,
                         output logic got, output int lat, output logic [31:0] rdata,
                         output logic rerr, output int psel_n, output int pen_n,
                         output logic stable, output logic ready_ok);
    int acc;
    got = 1'b0; lat = 0; rdata = '0; rerr = 1'b0;
    psel_n = 0; pen_n = 0; stable = 1'b1; ready_ok = 1'b0; acc = 0;
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    pready = 1'b1; pslverr = err;
    @(posedge pclk);
    for (int c = 1; c <= bound; c++) begin
      if (!got) begin
        @(negedge pclk);
        // Junk command while busy must never be captured.
        cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wd;
        if (rsp_valid) begin
          got = 1'b1; lat = c; rdata = rsp_rdata; rerr = rsp_err; ready_ok = cmd_ready;
          cmd_valid = 1'b0;
          pready = 1'b1;
        end else begin
          if (psel) psel_n++;
          if (penable) pen_n++;
          if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd)) stable = 1'b0;
          if (psel && penable) begin
            pready = (acc >= waits);
            acc++;
          end else begin
            pready = 1'b1;
          end
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic        got, rerr, stable, ready_ok;
    int          lat, psel_n, pen_n, rv_seen;
    logic [31:0] rdata;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    vecs[0] = '{1'b1, 8'h10, 32'h0000_00A5, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
    vecs[1] = '{1'b0, 8'h10, 32'h0BAD_F00D, 0, 1'b0, 32'h0000_00A5, 1'b0, 3};
    vecs[2] = '{1'b1, 8'h20, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000, 1'b0, 5};
    vecs[3] = '{1'b0, 8'h10, 32'h0000_1111, 4, 1'b0, 32'h0000_00A5, 1'b0, 7};
    vecs[4] = '{1'b1, 8'h30, 32'h1234_5678, 0, 1'b1, 32'h0000_0000, 1'b1, 3};
    vecs[5] = '{1'b0, 8'h20, 32'h0000_2222, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4};
    vecs[6] = '{1'b0, 8'h30, 32'h0000_3333, 0, 1'b1, 32'h1234_5678, 1'b1, 3};
    vecs[7] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 3, 1'b0, 32'h0000_0000, 1'b0, 6};
    vecs[8] = '{1'b0, 8'hFF, 32'h0000_0000, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 32'h0; pready = 1'b1; pslverr = 1'b0;

    repeat (3) @(negedge pclk);
    check("reset_outputs", {23'd0, psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready,
                            |paddr, |pwdata, |rsp_rdata}, 32'd0);
    presetn = 1'b1;
    #1;
    check("ready_after_release", 32'(cmd_ready), 32'd1);

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].slverr, 40,
              got, lat, rdata, rerr, psel_n, pen_n, stable, ready_ok);
      check($sformatf("v%0d_got", v), 32'(got), 32'd1);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v), 32'(rerr), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_psel_cycles", v), 32'(psel_n), 32'(vecs[v].waits + 2));
      check($sformatf("v%0d_penable_cycles", v), 32'(pen_n), 32'(vecs[v].waits + 1));
      check($sformatf("v%0d_apb_stable", v), 32'(stable), 32'd1);
      check($sformatf("v%0d_ready_with_rsp", v), 32'(ready_ok), 32'd1);
      @(negedge pclk);
      check($sformatf("v%0d_pulse_one_cycle", v), {30'd0, rsp_valid, rsp_err}, 32'd0);
      check($sformatf("v%0d_rdata_hold", v), rsp_rdata, vecs[v].exp_rdata);
    end

    // Reset in the middle of ACCESS aborts the write without a completion.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 32'h0000_0055;
    pready = 1'b0; pslverr = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("abort_in_access", {30'd0, psel, penable}, 32'd3);
    #2 presetn = 1'b0;
    #1;
    check("abort_outputs", {24'd0, psel, penable, rsp_valid, cmd_ready, pwrite,
                            |paddr, |pwdata, |rsp_rdata}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1; pready = 1'b1;
    #1;
    check("abort_ready_after_release", 32'(cmd_ready), 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (rsp_valid) rv_seen++;
    end
    check("abort_no_rsp", 32'(rv_seen), 32'd0);
    run_txn(1'b0, 8'h40, 32'h0, 0, 1'b0, 40, got, lat, rdata, rerr, psel_n, pen_n,
            stable, ready_ok);
    check("abort_write_dropped", rdata, 32'h0);
    check("abort_read_latency", 32'(lat), 32'd3);
    @(negedge pclk);

    // Slave never ready.
`ifdef APB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 8'h10, 32'h0, 1000, 1'b0, 100, got, lat, rdata, rerr, psel_n, pen_n,
            stable, ready_ok);
    check("timeout_got", 32'(got), 32'd1);
    check("timeout_latency", 32'(lat), 32'd18);
    check("timeout_err", 32'(rerr), 32'd1);
    check("timeout_rdata", rdata, 32'h0);
    check("timeout_penable_cycles", 32'(pen_n), 32'd16);
    @(negedge pclk);
    check("timeout_pulse_one_cycle", 32'(rsp_valid), 32'd0);
`else
    run_txn(1'b0, 8'h10, 32'h0, 1000, 1'b0, 100, got, lat, rdata, rerr, psel_n, pen_n,
            stable, ready_ok);
    check("no_timeout_no_rsp", 32'(got), 32'd0);
    check("no_timeout_still_access", {30'd0, psel, penable}, 32'd3);
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    pready = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
